// File: rtl/csr_timer_bank_if.sv
// CSR access bus between the CSR file (master) and the timer bank (slave).
interface csr_timer_bank_if #(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned SEL_W = 3
);
    logic [SEL_W-1:0] tmr_sel;
    logic [1:0]       reg_sel;
    logic             csr_we;
    logic [CNT_W-1:0] csr_wmask;
    logic [CNT_W-1:0] csr_wvalue;
    logic [CNT_W-1:0] csr_rvalue;

    modport master (
        output tmr_sel, reg_sel, csr_we, csr_wmask, csr_wvalue,
        input  csr_rvalue
    );

    modport slave (
        input  tmr_sel, reg_sel, csr_we, csr_wmask, csr_wvalue,
        output csr_rvalue
    );
endinterface

// File: rtl/csr_timer_bank.sv
// NTIMER independent countdown timers with masked CSR access, plus a
// free-running 64-bit stable counter that ignores debug halt.
module csr_timer_bank #(
    parameter int unsigned NTIMER = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned SEL_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    csr_timer_bank_if.slave    csr,
    input  logic               cnt_halt,
    output logic [NTIMER-1:0]  irq_pending,
    output logic               irq_any,
    output logic [63:0]        stable_cnt
);
    localparam logic [1:0] REG_TCFG  = 2'd0;
    localparam logic [1:0] REG_TVAL  = 2'd1;
    localparam logic [1:0] REG_TICLR = 2'd2;
    localparam logic [1:0] REG_TSTAT = 2'd3;

    logic             wr_ok;
    logic [CNT_W-1:0] tcfg_rd  [NTIMER];
    logic [CNT_W-1:0] tval_rd  [NTIMER];
    logic [CNT_W-1:0] tstat_rd [NTIMER];
    logic [CNT_W-1:0] rvalue_c;
    logic [63:0]      stable_q;

    // Widened compare so NTIMER == 2**SEL_W is representable.
    assign wr_ok = csr.csr_we &&
                   ({1'b0, csr.tmr_sel} < (SEL_W+1)'(NTIMER));

    for (genvar i = 0; i < NTIMER; i++) begin : g_tmr
        logic             en_q, en_d;
        logic             per_q, per_d;
        logic             pend_q, pend_d;
        logic             ie_q, ie_d;
        logic [CNT_W-3:0] initv_q, initv_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [CNT_W-1:0] cfg_old, cfg_new;
        logic             hit, cfg_we, clr, step;

        always_comb begin
            en_d    = en_q;
            per_d   = per_q;
            initv_d = initv_q;
            cnt_d   = cnt_q;
            ie_d    = ie_q;
            hit     = wr_ok && (csr.tmr_sel == SEL_W'(i));
            cfg_we  = hit && (csr.reg_sel == REG_TCFG);
            clr     = hit && (csr.reg_sel == REG_TICLR) &&
                      csr.csr_wmask[0] && csr.csr_wvalue[0];
            cfg_old = {initv_q, per_q, en_q};
            cfg_new = (csr.csr_wmask & csr.csr_wvalue) | (~csr.csr_wmask & cfg_old);
            step    = en_q && !cnt_halt && (cnt_q != '1) && !cfg_we;

            // A TCFG write takes priority over counting on the same edge.
            if (cfg_we) begin
                en_d    = cfg_new[0];
                per_d   = cfg_new[1];
                initv_d = cfg_new[CNT_W-1:2];
                if (cfg_new[0]) begin
                    cnt_d = {cfg_new[CNT_W-1:2], 2'b00};
                end
            end else if (step) begin
                if (cnt_q == '0) begin
                    cnt_d = per_q ? {initv_q, 2'b00} : '1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            pend_d = (step && (cnt_q == '0)) || (pend_q && !clr);

            if (hit && (csr.reg_sel == REG_TSTAT) && csr.csr_wmask[1]) begin
                ie_d = csr.csr_wvalue[1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                en_q    <= 1'b0;
                per_q   <= 1'b0;
                initv_q <= '0;
                cnt_q   <= '1;
                pend_q  <= 1'b0;
                ie_q    <= 1'b0;
            end else begin
                en_q    <= en_d;
                per_q   <= per_d;
                initv_q <= initv_d;
                cnt_q   <= cnt_d;
                pend_q  <= pend_d;
                ie_q    <= ie_d;
            end
        end

        assign irq_pending[i] = pend_q & ie_q;
        assign tcfg_rd[i]     = cfg_old;
        assign tval_rd[i]     = cnt_q;
        assign tstat_rd[i]    = {(CNT_W-2)'(0), ie_q, pend_q};
    end

    // Read mux; out-of-range selects and TICLR read as zero.
    always_comb begin
        rvalue_c = '0;
        for (int unsigned i = 0; i < NTIMER; i++) begin
            if (csr.tmr_sel == SEL_W'(i)) begin
                case (csr.reg_sel)
                    REG_TCFG:  rvalue_c = tcfg_rd[i];
                    REG_TVAL:  rvalue_c = tval_rd[i];
                    REG_TSTAT: rvalue_c = tstat_rd[i];
                    default:   rvalue_c = '0;
                endcase
            end
        end
    end

    assign csr.csr_rvalue = rvalue_c;
    assign irq_any        = |irq_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= '0;
        end else begin
            stable_q <= stable_q + 64'd1;
        end
    end

    assign stable_cnt = stable_q;
endmodule

// File: tb/tb_csr_timer_bank.sv
// Bench for csr_timer_bank: directed scenarios plus random CSR traffic,
// all checked against a register-level behavioural model every cycle.
module tb_csr_timer_bank;
    localparam int unsigned NT = 4;
    localparam int unsigned CW = 32;
    localparam int unsigned SW = 3;
    localparam logic [31:0] ONES = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          cnt_halt;
    logic [NT-1:0] irq_pending;
    logic          irq_any;
    logic [63:0]   stable_cnt;

    csr_timer_bank_if #(.CNT_W(CW), .SEL_W(SW)) bus ();

    csr_timer_bank #(.NTIMER(NT), .CNT_W(CW), .SEL_W(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .csr         (bus),
        .cnt_halt    (cnt_halt),
        .irq_pending (irq_pending),
        .irq_any     (irq_any),
        .stable_cnt  (stable_cnt)
    );

    always #10 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: each timer kept as its TCFG word, current count, pend and ie.
    logic [31:0] m_cfg [NT];
    logic [31:0] m_cnt [NT];
    bit          m_pend[NT];
    bit          m_ie  [NT];
    logic [63:0] m_stable;
    int          exp_seq [5] = '{3, 2, 1, 0, 4};

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_read(int sel, int r);
        if (sel >= int'(NT)) return 32'd0;
        case (r)
            0:       return m_cfg[sel];
            1:       return m_cnt[sel];
            3:       return {30'd0, m_ie[sel], m_pend[sel]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [NT-1:0] m_irq();
        logic [NT-1:0] v = '0;
        for (int t = 0; t < int'(NT); t++) v[t] = m_pend[t] & m_ie[t];
        return v;
    endfunction

    always @(posedge clk) begin : model
        logic [31:0] wm, wv;
        int          sel, r;
        bit          we_ok, hit, set, clear;
        if (rst) begin
            for (int t = 0; t < int'(NT); t++) begin
                m_cfg[t] = 32'd0; m_cnt[t] = ONES; m_pend[t] = 0; m_ie[t] = 0;
            end
            m_stable = 64'd0;
        end else begin
            wm = bus.csr_wmask; wv = bus.csr_wvalue;
            sel = int'(bus.tmr_sel); r = int'(bus.reg_sel);
            we_ok = bus.csr_we && (sel < int'(NT));
            for (int t = 0; t < int'(NT); t++) begin
                hit = we_ok && (sel == t);
                set = 0;
                if (hit && r == 0) begin
                    m_cfg[t] = (wm & wv) | (~wm & m_cfg[t]);
                    if (m_cfg[t][0]) m_cnt[t] = m_cfg[t] & ~32'h3;
                end else if (m_cfg[t][0] && !cnt_halt && m_cnt[t] != ONES) begin
                    if (m_cnt[t] == 32'd0) begin
                        set = 1;
                        m_cnt[t] = m_cfg[t][1] ? (m_cfg[t] & ~32'h3) : ONES;
                    end else begin
                        m_cnt[t] = m_cnt[t] - 32'd1;
                    end
                end
                clear = hit && r == 2 && wm[0] && wv[0];
                m_pend[t] = set || (m_pend[t] && !clear);
                if (hit && r == 3 && wm[1]) m_ie[t] = wv[1];
            end
            m_stable = m_stable + 64'd1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("rvalue", bus.csr_rvalue, m_read(int'(bus.tmr_sel), int'(bus.reg_sel)));
            check("irq_pending", irq_pending, m_irq());
            check("irq_any", irq_any, |m_irq());
            check("stable_cnt", stable_cnt, m_stable);
        end
    end

    task automatic wr(int sel, int r, logic [31:0] mask, logic [31:0] val);
        bus.tmr_sel = SW'(sel); bus.reg_sel = 2'(r);
        bus.csr_wmask = mask; bus.csr_wvalue = val; bus.csr_we = 1'b1;
        @(negedge clk);
        bus.csr_we = 1'b0;
    endtask

    task automatic rd(int sel, int r, logic [31:0] exp, string name);
        bus.csr_we = 1'b0; bus.tmr_sel = SW'(sel); bus.reg_sel = 2'(r);
        #1;
        check(name, bus.csr_rvalue, exp);
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tval(int sel, logic [31:0] val);
        bit ok = 0;
        bus.csr_we = 1'b0; bus.tmr_sel = SW'(sel); bus.reg_sel = 2'd1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.csr_rvalue == val) begin ok = 1; break; end
            @(negedge clk);
        end
        check("wait_tval_timeout", ok, 1);
    endtask

    initial begin
        logic [63:0] s0;
        rst = 1'b1; cnt_halt = 1'b0;
        bus.csr_we = 1'b0; bus.tmr_sel = '0; bus.reg_sel = '0;
        bus.csr_wmask = '0; bus.csr_wvalue = '0;
        idle(3);
        chk_en = 1'b1;

        rd(0, 0, 32'd0, "rst_tcfg");
        rd(0, 1, ONES,  "rst_tval");
        rd(0, 2, 32'd0, "rst_ticlr");
        rd(0, 3, 32'd0, "rst_tstat");
        check("rst_irq_any", irq_any, 0);
        rst = 1'b0;
        idle(1);
        check("stable_after_rst", stable_cnt, 64'd1);

        // One-shot timer 1.
        wr(1, 3, ONES, 32'h2);
        wr(1, 0, ONES, 32'h11);
        rd(1, 1, 32'h10, "t1_load");
        idle(16);
        rd(1, 1, 32'd0, "t1_zero");
        check("t1_no_irq_yet", irq_pending, 4'b0000);
        idle(1);
        rd(1, 1, ONES, "t1_expired");
        rd(1, 3, 32'h3, "t1_pend");
        check("t1_irq", irq_pending, 4'b0010);
        rd(0, 1, ONES, "t0_untouched");
        idle(2);
        rd(1, 1, ONES, "t1_idle");
        wr(1, 2, 32'h1, 32'h1);
        rd(1, 3, 32'h2, "t1_clr");

        // Periodic timer 2.
        wr(2, 3, ONES, 32'h2);
        wr(2, 0, ONES, 32'h7);
        rd(2, 1, 32'd4, "t2_load");
        for (int k = 0; k < 5; k++) begin
            idle(1);
            rd(2, 1, 32'(exp_seq[k]), "t2_seq");
        end
        rd(2, 3, 32'h3, "t2_pend_set");
        wr(2, 2, 32'h1, 32'h1);
        rd(2, 3, 32'h2, "t2_pend_clr");
        wait_tval(2, 32'd0);
        wr(2, 2, 32'h1, 32'h1);
        rd(2, 3, 32'h3, "t2_set_wins");
        wr(2, 2, 32'h1, 32'h1);
        rd(2, 3, 32'h2, "t2_clr_again");

        // Halt with timer 2 sitting at zero.
        wait_tval(2, 32'd0);
        s0 = stable_cnt;
        cnt_halt = 1'b1;
        idle(10);
        cnt_halt = 1'b0;
        check("halt_stable_delta", stable_cnt - s0, 64'd10);
        rd(2, 1, 32'd0, "halt_frozen");
        rd(2, 3, 32'h2, "halt_no_pend");
        idle(1);
        rd(2, 3, 32'h3, "post_halt_pend");
        rd(2, 1, 32'd4, "post_halt_reload");

        // Masked en toggle on a running timer.
        wr(2, 0, 32'h1, 32'h0);
        rd(2, 0, 32'h6, "mask_en_off");
        rd(2, 1, 32'd4, "mask_hold");
        idle(3);
        rd(2, 1, 32'd4, "stopped_hold");
        wr(2, 0, 32'h1, 32'h1);
        rd(2, 1, 32'd4, "mask_reload");
        idle(1);
        rd(2, 1, 32'd3, "run_again");

        // Out-of-range select.
        wr(5, 0, ONES, ONES);
        rd(5, 0, 32'd0, "oor_tcfg");
        rd(5, 1, 32'd0, "oor_tval");
        rd(0, 0, 32'd0, "oor_no_effect");
        idle(1);

        // Random CSR traffic, model-checked each cycle.
        repeat (1500) begin
            bus.csr_we     = ($urandom_range(0, 3) == 0);
            bus.tmr_sel    = SW'($urandom_range(0, 7));
            bus.reg_sel    = 2'($urandom_range(0, 3));
            bus.csr_wmask  = $urandom_range(0, 1) ? ONES : $urandom;
            bus.csr_wvalue = $urandom_range(0, 1) ? 32'($urandom_range(0, 63)) : $urandom;
            cnt_halt       = ($urandom_range(0, 7) == 0);
            @(negedge clk);
        end
        bus.csr_we = 1'b0; cnt_halt = 1'b0;

        // Reset in the middle of counting.
        wr(0, 0, ONES, 32'h101);
        idle(3);
        rst = 1'b1;
        idle(1);
        rd(0, 0, 32'd0, "midrst_tcfg");
        rd(0, 1, ONES,  "midrst_tval");
        rd(2, 3, 32'd0, "midrst_tstat");
        check("midrst_irq_any", irq_any, 0);
        check("midrst_stable", stable_cnt, 64'd0);
        rst = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
